// File: rtl/logic_op_unit_pkg.sv
// logic_op_unit_pkg: op encodings, FSM states and fold-op mapping for logic_op_unit
package logic_op_unit_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {ST_IDLE, ST_ACC} state_e;

    // NAND folds with AND; the inversion happens only once, at emit
    function automatic logic [1:0] fold_op(input logic [1:0] op);
        return op == OP_NAND ? OP_AND : op;
    endfunction
endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: raw bitwise beat op (NAND yields the un-inverted a&b)
module logic_op_core
    import logic_op_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r
);
    assign r = op == OP_OR ? a | b : op == OP_XOR ? a ^ b : a & b;
endmodule

// File: rtl/logic_op_unit.sv
// logic_op_unit: registered bitwise op unit with multi-beat accumulate mode
module logic_op_unit
    import logic_op_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] out_beats
);
    state_e           state, state_n;
    logic [WIDTH-1:0] acc, r, acc_f, res;
    logic [1:0]       op_q, beat_op;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign beat_op  = state == ST_ACC ? op_q : in_op;
    assign cnt_nxt  = &cnt ? cnt : cnt + CNT_W'(1);

    logic_op_core #(.WIDTH(WIDTH)) u_beat (.a(in_a), .b(in_b), .op(beat_op), .r(r));
    logic_op_core #(.WIDTH(WIDTH)) u_fold (.a(acc), .b(r), .op(fold_op(op_q)), .r(acc_f));

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        res     = state == ST_ACC ? acc_f : r;
        res     = beat_op == OP_NAND ? ~res : res;
        if (accept) begin
            if (state == ST_IDLE) begin
                emit    = !in_acc || in_last;
                state_n = in_acc && !in_last ? ST_ACC : ST_IDLE;
            end else begin
                emit    = in_last;
                state_n = in_last ? ST_IDLE : ST_ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            op_q      <= OP_AND;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_zero  <= 1'b0;
            out_ones  <= 1'b0;
            out_beats <= '0;
        end else begin
            state <= state_n;
            if (accept && state == ST_IDLE) begin
                acc  <= r;
                op_q <= in_op;
                cnt  <= CNT_W'(1);
            end else if (accept) begin
                acc <= acc_f;
                cnt <= cnt_nxt;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_c     <= res;
                out_zero  <= res == '0;
                out_ones  <= &res;
                out_beats <= state == ST_ACC ? cnt_nxt : CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
